mealy_scan_ctrl: RTL
====================

Name: mealy_scan_ctrl

Overview:
- Controller that sequences a serial Mealy pattern detector over a stream of parallel words.
- Accepts WORD_W-bit words on a valid/ready input handshake, then shifts each word MSB-first into the detector, one bit per clock.
- Counts the detector's hits per word and returns the count on a valid/ready output handshake.
- Keeps a saturating running total of hits; sits between a parallel data source and the bit-serial detector datapath.

Parameters:
- WORD_W, 8: bits per input word.
- PAT_W, 4: pattern length, 2..WORD_W.
- PAT, 4'b1011: pattern to detect, MSB is the first bit received.
- CARRY, 0: 1 = detector history persists across words (stream mode); 0 = history cleared at each word accept.
- CNT_W, 16: width of total_hits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while rst=0.
- in_valid  in  1  source has a word.
- in_data  in  WORD_W  word to scan.
- in_ready  out  1  controller can accept a word; high only in IDLE.
- out_valid  out  1  hit count available.
- out_hits  out  $clog2(WORD_W+1)  hits in the last word.
- out_ready  in  1  sink accepts the result.
- ser_bit  out  1  bit currently presented to the detector.
- ser_hit  out  1  Mealy detector output; combinational, forced to 0 outside SHIFT.
- total_hits  out  CNT_W  saturating count of all hits since reset.
- busy  out  1  high in SHIFT or REPORT.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_hits=0, total_hits=0, ser_bit=0, ser_hit=0, busy=0.
  - Detector history and fill count cleared.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_data into the shift register, bit_cnt=0, hit_cnt=0, go to SHIFT.
  - If CARRY=0, also clear the detector history on the same edge.
- SHIFT:
  - ser_bit = shift register MSB.
  - ser_hit = 1 when the last PAT_W-1 history bits concatenated with ser_bit equal PAT, and at least PAT_W-1 valid bits are in the history.
  - Each edge: history shifts in ser_bit, shift register shifts left, bit_cnt+1, hit_cnt += ser_hit.
  - After exactly WORD_W edges, go to REPORT: out_hits = final hit_cnt, total_hits += final hit_cnt.
  - total_hits saturates at 2^CNT_W-1 and never wraps.
- REPORT:
  - out_valid=1; out_hits held stable until an edge with out_ready=1, then go to IDLE.
- Latency: a word accepted at edge k gives out_valid=1 after edge k+WORD_W.
- Throughput: with out_ready tied high, one word every WORD_W+2 cycles.
- Detection overlaps: a bit may complete one match and start the next.
- Boundary conditions:
  - in_valid while busy is ignored; the source holds its word.
  - in_data is sampled only on the accept edge.
  - out_ready is ignored outside REPORT.
  - Reset during SHIFT or REPORT aborts the word: no out_valid, result discarded.
  - CARRY=1: a pattern spanning two words counts in the later word.

Decomposition:
- Shared header/package holds:
  - State encoding localparams IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2.
  - Default PAT/PAT_W constants.
  - A clog2-based width macro for out_hits.
- One sub-module: mealy_pattern_det.
  - Ports: clk, rst, en, clr, d_in, hit.
  - Holds a PAT_W-1-bit history and a fill counter; hit is combinational.
  - The controller instantiates it, driving en in SHIFT and clr on accept when CARRY=0.

Test Plan:
- Reset: hold rst=0 with in_valid=1 for 3 cycles -> in_ready=1, out_valid=0, busy=0, total_hits=0; no word accepted.
- PAT=1011, CARRY=0, word 8'b1011_1011, out_ready=1 -> ser_hit pulses on bits 3 and 7; out_valid high 8 cycles after accept; out_hits=2, total_hits=2.
- Overlap: word 8'b1011_0110 -> out_hits=2, with the match ending at bit 3 sharing that bit with the next match; total_hits=4.
- Cross-word: words 8'b0000_0101 then 8'b1000_0000.
  - CARRY=1 -> out_hits 0 then 1.
  - CARRY=0 -> out_hits 0 then 0.
- Backpressure: out_ready=0 for 5 cycles in REPORT with in_valid=1 -> out_valid and out_hits stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-SHIFT and saturation:
  - rst=0 during bit 4 -> immediately out_valid=0, in_ready=1, total_hits=0; the next word 8'b1011_1011 gives out_hits=2.
  - CNT_W=2, two words of 2 hits -> total_hits=3 (saturated).

Source files
------------

// File: rtl/mealy_scan_ctrl_pkg.sv
// mealy_scan_ctrl_pkg
//   Shared definitions for the scan controller and its serial pattern detector.
//   - state_e     : controller FSM encoding (IDLE / SHIFT / REPORT)
//   - DEF_PAT_W   : default pattern length
//   - DEF_PAT     : default pattern, MSB is the first bit received
//   - hits_w()    : width needed to hold a hit count of 0..n
package mealy_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int              DEF_PAT_W = 4;
  localparam logic [3:0]      DEF_PAT   = 4'b1011;

  // A word of n bits can produce at most n hits, so the count needs n+1 codes.
  function automatic int hits_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mealy_scan_ctrl_det.sv
// mealy_pattern_det
//   Bit-serial Mealy detector. Keeps the last PAT_W-1 bits seen plus a fill
//   counter so that no match is reported until enough real history exists.
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  asynchronous active-low reset
//     en    in  consume d_in this cycle; also gates hit
//     clr   in  drop history and fill count (takes priority over en)
//     d_in  in  current serial bit
//     hit   out combinational: history concatenated with d_in equals PAT
module mealy_pattern_det #(
  parameter int               PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT   = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic d_in,
  output logic hit
);

  localparam int H_W    = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W);

  logic [H_W-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full;

  assign full = (fill_q == FILL_W'(H_W));

  // Mealy output: depends on the incoming bit, so a match is flagged in the
  // same cycle its last bit is presented.
  assign hit = en && full && ({hist_q, d_in} == PAT);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      // Truncating the concatenation drops the oldest bit.
      hist_d = H_W'({hist_q, d_in});
      if (!full) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mealy_scan_ctrl.sv
// mealy_scan_ctrl
//   Accepts parallel words, shifts each MSB-first through mealy_pattern_det,
//   counts hits per word and reports the count; keeps a saturating total.
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid, once raised, is held with its data until that edge.
//   Ports:
//     clk, rst            clock / asynchronous active-low reset
//     in_valid/in_ready   word input handshake, in_data sampled on accept
//     out_valid/out_ready result handshake, out_hits stable while out_valid
//     ser_bit, ser_hit    bit presented to the detector and its Mealy output
//     total_hits          saturating total of hits since reset
//     busy                high in SHIFT or REPORT
//     dbg_state           current FSM state
module mealy_scan_ctrl
  import mealy_scan_ctrl_pkg::*;
#(
  parameter int               WORD_W = 8,
  parameter int               PAT_W  = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT    = PAT_W'(DEF_PAT),
  parameter int               CARRY  = 0,
  parameter int               CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WORD_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [hits_w(WORD_W)-1:0]     out_hits,
  input  logic                          out_ready,
  output logic                          ser_bit,
  output logic                          ser_hit,
  output logic [CNT_W-1:0]              total_hits,
  output logic                          busy,
  output state_e                        dbg_state
);

  localparam int HW    = hits_w(WORD_W);
  localparam int BC_W  = $clog2(WORD_W);
  localparam int SUM_W = ((CNT_W > HW) ? CNT_W : HW) + 1;
  localparam logic [CNT_W-1:0] TOT_MAX = '1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [HW-1:0]     out_hits_q, out_hits_d;
  logic [CNT_W-1:0]  total_q, total_d;

  logic              accept;
  logic              shifting;
  logic              det_hit;
  logic              det_clr;
  logic [HW-1:0]     final_hits;
  logic [SUM_W-1:0]  sum;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shifting = (state_q == SHIFT);
  assign det_clr  = accept && (CARRY == 0);

  mealy_pattern_det #(
    .PAT_W (PAT_W),
    .PAT   (PAT)
  ) u_det (
    .clk  (clk),
    .rst  (rst),
    .en   (shifting),
    .clr  (det_clr),
    .d_in (sreg_q[WORD_W-1]),
    .hit  (det_hit)
  );

  // Count including the bit being consumed on this edge.
  assign final_hits = hit_cnt_q + HW'(det_hit);
  assign sum        = SUM_W'(total_q) + SUM_W'(final_hits);

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    out_hits_d = out_hits_q;
    total_d    = total_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d    = in_data;
          bit_cnt_d = '0;
          hit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d    = {sreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        hit_cnt_d = final_hits;
        if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
          out_hits_d = final_hits;
          total_d    = (sum > SUM_W'(TOT_MAX)) ? TOT_MAX : sum[CNT_W-1:0];
          state_d    = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      out_hits_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      out_hits_q <= out_hits_d;
      total_q    <= total_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == REPORT);
  assign busy       = (state_q == SHIFT) || (state_q == REPORT);
  assign out_hits   = out_hits_q;
  assign total_hits = total_q;
  assign ser_bit    = shifting ? sreg_q[WORD_W-1] : 1'b0;
  assign ser_hit    = det_hit;
  assign dbg_state  = state_q;

endmodule
